// File: rtl/correlation_reader.sv
// rtl/correlation_reader.sv - times integration periods, snapshots the correlator bus and streams it as framed bytes
module correlation_reader #(
   parameter int NUM_BASELINES = 8,
   parameter int HEAD_SIZE     = 0,
   parameter int TAIL_SIZE     = 1,
   parameter int RESOLUTION    = 24,
   localparam int LAGS_RAW     = HEAD_SIZE + TAIL_SIZE - 1,
   // A degenerate head/tail pair still keeps one lag so the bus never collapses to zero width
   localparam int LAGS         = (LAGS_RAW < 1) ? 1 : LAGS_RAW,
   localparam int CHANNELS     = NUM_BASELINES * LAGS,
   localparam int WORDS        = 2 * CHANNELS,
   localparam int BPW          = (RESOLUTION + 7) / 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [WORDS*RESOLUTION-1:0]   pulses,
   input  logic                          enable,
   input  logic [31:0]                   integration_cycles,
   output logic                          corr_clear,
   output logic [7:0]                    tx_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic                          busy,
   output logic                          overrun,
   output logic [7:0]                    frame_cnt
);

   localparam int WIW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [WIW-1:0] LAST_WORD  = WIW'(WORDS - 1);
   localparam logic [BIW-1:0] FIRST_BYTE = BIW'(BPW - 1);
   localparam logic [7:0]     SYNC_BYTE  = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER0,
      S_HEADER1,
      S_DATA,
      S_CHECKSUM
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [31:0]           period_cnt;
   logic [31:0]           period_max;
   logic                  period_end;
   logic                  start;
   logic                  accept;
   logic [RESOLUTION-1:0] snap [WORDS];
   logic [WIW-1:0]        word_idx;
   logic [BIW-1:0]        byte_idx;
   logic [7:0]            csum;
   logic [BPW*8-1:0]      cur_word;
   logic [7:0]            data_byte;

   // integration_cycles of 0 behaves like 1: a period end on every enabled cycle
   assign period_max = (integration_cycles == 32'd0) ? 32'd0 : integration_cycles - 32'd1;
   assign period_end = enable & (period_cnt == period_max);

   assign busy     = (state != S_IDLE);
   assign tx_valid = busy;
   assign accept   = tx_valid & tx_ready;
   assign start    = period_end & (state == S_IDLE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:     if (period_end) state_next = S_HEADER0;
         S_HEADER0:  if (accept) state_next = S_HEADER1;
         S_HEADER1:  if (accept) state_next = S_DATA;
         S_DATA:     if (accept && word_idx == LAST_WORD && byte_idx == '0) state_next = S_CHECKSUM;
         S_CHECKSUM: if (accept) state_next = S_IDLE;
         default:    state_next = S_IDLE;
      endcase
   end

   // Byte mux is driven only by registered state and counters, never by tx_ready
   always_comb begin
      cur_word = '0;
      cur_word[RESOLUTION-1:0] = snap[word_idx];
      data_byte = 8'(cur_word >> {byte_idx, 3'b000});
   end

   always_comb begin
      tx_data = 8'h00;
      case (state)
         S_HEADER0:  tx_data = SYNC_BYTE;
         S_HEADER1:  tx_data = frame_cnt;
         S_DATA:     tx_data = data_byte;
         S_CHECKSUM: tx_data = csum;
         default:    tx_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         period_cnt <= '0;
         corr_clear <= 1'b0;
         overrun    <= 1'b0;
         frame_cnt  <= '0;
         csum       <= '0;
         word_idx   <= '0;
         byte_idx   <= '0;
         for (int k = 0; k < WORDS; k++) snap[k] <= '0;
      end else begin
         period_cnt <= (!enable || period_end) ? 32'd0 : period_cnt + 32'd1;
         // Clear pulses even when the snapshot is dropped so every period has equal length
         corr_clear <= ~enable | period_end;
         overrun    <= period_end & (state != S_IDLE);

         if (start) begin
            for (int k = 0; k < WORDS; k++) snap[k] <= pulses[k*RESOLUTION +: RESOLUTION];
            word_idx <= '0;
            byte_idx <= FIRST_BYTE;
            csum     <= '0;
         end

         if (accept) begin
            if (state == S_HEADER1 || state == S_DATA) csum <= csum + tx_data;
            if (state == S_DATA) begin
               if (byte_idx == '0) begin
                  byte_idx <= FIRST_BYTE;
                  word_idx <= word_idx + 1'b1;
               end else begin
                  byte_idx <= byte_idx - 1'b1;
               end
            end
            if (state == S_CHECKSUM) frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

endmodule
